// File: rtl/vend_disp_ctrl.sv
// Vending-machine display controller: fixed-priority screen arbiter with hold/lock and a
// time-multiplexed 7-segment scan engine. Define VEND_DISP_BLINK_EN to add per-digit blinking.
module vend_disp_ctrl #(
    parameter int unsigned NUM_SCREENS = 8,
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SCAN_DIV    = 100000,
`ifdef VEND_DISP_BLINK_EN
    parameter int unsigned BLINK_DIV   = 25000000,
`endif
    parameter int unsigned MIN_HOLD    = 50000000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                disp_on,
    input  logic [NUM_SCREENS-1:0]              req,
    input  logic                                lock,
    input  logic [NUM_SCREENS*NUM_DIGITS*4-1:0] scr_data,
`ifdef VEND_DISP_BLINK_EN
    input  logic [NUM_DIGITS-1:0]               blink_mask,
`endif
    output logic [$clog2(NUM_SCREENS)-1:0]      cur_screen,
    output logic                                screen_chg,
    output logic [NUM_DIGITS-1:0]               seg_en,
    output logic [7:0]                          seg_out
);

    localparam int unsigned SW = $clog2(NUM_SCREENS);
    localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(MIN_HOLD - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StOff, StMain, StActive} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] screen_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] presc_q;
    logic [DW-1:0] digit_q;
    logic [SW-1:0] win;
    logic          has_win;
    logic          chg_d;
    logic          blank;
    logic [3:0]    cur_nib;

    logic [3:0] nib [NUM_SCREENS][NUM_DIGITS];

    for (genvar s = 0; s < NUM_SCREENS; s++) begin : g_scr
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
            assign nib[s][d] = scr_data[(s*NUM_DIGITS+d)*4 +: 4];
        end
    end

    assign cur_nib = nib[cur_screen][digit_q];

    function automatic logic [7:0] decode(input logic [3:0] v);
        unique case (v)
            4'h0:    decode = 8'h3F;
            4'h1:    decode = 8'h06;
            4'h2:    decode = 8'h5B;
            4'h3:    decode = 8'h4F;
            4'h4:    decode = 8'h66;
            4'h5:    decode = 8'h6D;
            4'h6:    decode = 8'h7D;
            4'h7:    decode = 8'h07;
            4'h8:    decode = 8'h7F;
            4'h9:    decode = 8'h6F;
            4'hA:    decode = 8'h40;
            4'hB:    decode = 8'h73;
            4'hC:    decode = 8'h39;
            default: decode = 8'h00;
        endcase
    endfunction

    // Ascending scan: the last set bit seen is the highest-priority request.
    always_comb begin
        win     = '0;
        has_win = 1'b0;
        for (int unsigned i = 1; i < NUM_SCREENS; i++) begin
            if (req[i]) begin
                win     = SW'(i);
                has_win = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        screen_d = cur_screen;
        hold_d   = (hold_q != '0) ? hold_q - 1'b1 : '0;
        if (!disp_on) begin
            state_d  = StOff;
            screen_d = '0;
            hold_d   = '0;
        end else begin
            case (state_q)
                StOff: state_d = StMain;
                StMain: begin
                    if (!lock && has_win) begin
                        state_d  = StActive;
                        screen_d = win;
                        hold_d   = HOLD_LOAD;
                    end
                end
                StActive: begin
                    if (!lock) begin
                        if (has_win && win > cur_screen) begin
                            screen_d = win;
                            hold_d   = HOLD_LOAD;
                        end else if (!req[cur_screen] && hold_q == '0) begin
                            if (has_win) begin
                                screen_d = win;
                                hold_d   = HOLD_LOAD;
                            end else begin
                                state_d  = StMain;
                                screen_d = '0;
                            end
                        end
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    assign chg_d = (screen_d != cur_screen);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StOff;
            cur_screen <= '0;
            screen_chg <= 1'b0;
            hold_q     <= '0;
            presc_q    <= '0;
            digit_q    <= '0;
            seg_en     <= '0;
            seg_out    <= '0;
        end else begin
            state_q    <= state_d;
            cur_screen <= screen_d;
            screen_chg <= chg_d;
            hold_q     <= hold_d;

            // A new screen always restarts the scan from digit 0.
            if (!disp_on || state_q == StOff || chg_d) begin
                presc_q <= '0;
                digit_q <= '0;
            end else if (presc_q == SCAN_LAST) begin
                presc_q <= '0;
                digit_q <= (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            if (disp_on && state_q != StOff) begin
                seg_en  <= NUM_DIGITS'(1) << digit_q;
                seg_out <= blank ? 8'h00 : decode(cur_nib);
            end else begin
                seg_en  <= '0;
                seg_out <= '0;
            end
        end
    end

`ifdef VEND_DISP_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (chg_d) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blank = blink_q & blink_mask[digit_q];
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_vend_disp_ctrl.sv
// Directed bench for vend_disp_ctrl: bring-up scan, decode, priority/preempt, hold, lock,
// display disable and asynchronous reset, with SCAN_DIV=4 and MIN_HOLD=10.
module tb_vend_disp_ctrl;

    logic         clk;
    logic         rst;
    logic         disp_on;
    logic [7:0]   req;
    logic         lock;
    logic [255:0] scr_data;
    logic [2:0]   cur_screen;
    logic         screen_chg;
    logic [7:0]   seg_en;
    logic [7:0]   seg_out;

    int tests = 0;
    int fails = 0;

    vend_disp_ctrl #(
        .NUM_SCREENS(8),
        .NUM_DIGITS (8),
        .SCAN_DIV   (4),
        .MIN_HOLD   (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_on   (disp_on),
        .req       (req),
        .lock      (lock),
        .scr_data  (scr_data),
        .cur_screen(cur_screen),
        .screen_chg(screen_chg),
        .seg_en    (seg_en),
        .seg_out   (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_en;

        // Screen s shows digit value s, except a few overrides for glyph checks.
        for (int s = 0; s < 8; s++) begin
            for (int d = 0; d < 8; d++) begin
                scr_data[(s*8+d)*4 +: 4] = 4'(s);
            end
        end
        scr_data[(0*8+0)*4 +: 4] = 4'h3;
        scr_data[(0*8+1)*4 +: 4] = 4'hA;
        scr_data[(0*8+2)*4 +: 4] = 4'hE;
        scr_data[(3*8+0)*4 +: 4] = 4'hB;

        rst     = 1'b1;
        disp_on = 1'b0;
        req     = 8'h00;
        lock    = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_cur_screen", 32'(cur_screen), 32'h0);
        check("rst_seg_en", 32'(seg_en), 32'h0);
        check("rst_seg_out", 32'(seg_out), 32'h0);
        check("rst_screen_chg", 32'(screen_chg), 32'h0);
        tick();
        tick();

        // Bring-up
        rst     = 1'b1;
        disp_on = 1'b1;
        tick();
        check("bringup_first_en", 32'(seg_en), 32'h0);
        tick();
        check("scan_d0_en", 32'(seg_en), 32'h01);
        check("decode_3", 32'(seg_out), 32'h4F);
        for (int i = 1; i <= 8; i++) begin
            repeat (4) tick();
            exp_en = 8'h01 << (i % 8);
            check("scan_step_en", 32'(seg_en), 32'(exp_en));
            if (i == 1) check("decode_dash", 32'(seg_out), 32'h40);
            if (i == 2) check("decode_blank", 32'(seg_out), 32'h00);
        end

        // Priority and preemption
        req = 8'h04;
        tick();
        check("sel2_cur", 32'(cur_screen), 32'h2);
        check("sel2_chg", 32'(screen_chg), 32'h1);
        tick();
        check("sel2_chg_clear", 32'(screen_chg), 32'h0);
        check("sel2_seg_en", 32'(seg_en), 32'h01);
        check("sel2_seg_out", 32'(seg_out), 32'h5B);
        repeat (4) tick();
        check("sel2_scan_d1", 32'(seg_en), 32'h02);
        req = 8'h84;
        tick();
        check("preempt7_cur", 32'(cur_screen), 32'h7);
        check("preempt7_chg", 32'(screen_chg), 32'h1);
        req = 8'h00;
        tick();
        check("preempt7_digit_reset", 32'(seg_en), 32'h01);
        check("preempt7_seg_out", 32'(seg_out), 32'h07);
        repeat (10) tick();
        check("expire7_main", 32'(cur_screen), 32'h0);

        // Minimum hold
        req = 8'h08;
        tick();
        check("hold3_cur", 32'(cur_screen), 32'h3);
        check("hold3_chg", 32'(screen_chg), 32'h1);
        req = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("hold3_stay", 32'(cur_screen), 32'h3);
            if (i == 1) begin
                check("hold3_chg_clear", 32'(screen_chg), 32'h0);
                check("decode_P", 32'(seg_out), 32'h73);
            end
        end
        tick();
        check("hold3_return_main", 32'(cur_screen), 32'h0);
        check("hold3_return_chg", 32'(screen_chg), 32'h1);

        // Lock
        req = 8'h08;
        tick();
        check("lock_pre_cur", 32'(cur_screen), 32'h3);
        lock = 1'b1;
        req  = 8'h40;
        repeat (12) tick();
        check("lock_frozen_cur", 32'(cur_screen), 32'h3);
        check("lock_frozen_chg", 32'(screen_chg), 32'h0);
        lock = 1'b0;
        tick();
        check("unlock_cur", 32'(cur_screen), 32'h6);
        check("unlock_chg", 32'(screen_chg), 32'h1);
        tick();
        check("unlock_seg_en", 32'(seg_en), 32'h01);
        check("unlock_seg_out", 32'(seg_out), 32'h7D);

        // Display disable during ACTIVE
        disp_on = 1'b0;
        tick();
        check("off_seg_en", 32'(seg_en), 32'h0);
        check("off_seg_out", 32'(seg_out), 32'h0);
        check("off_cur", 32'(cur_screen), 32'h0);
        disp_on = 1'b1;
        tick();
        tick();
        check("reon_cur", 32'(cur_screen), 32'h6);
        tick();
        check("reon_seg_en", 32'(seg_en), 32'h01);
        check("reon_seg_out", 32'(seg_out), 32'h7D);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        check("async_rst_cur", 32'(cur_screen), 32'h0);
        check("async_rst_seg_en", 32'(seg_en), 32'h0);
        check("async_rst_seg_out", 32'(seg_out), 32'h0);
        #10 rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_disp_ctrl.md
Name: vend_disp_ctrl

Overview:
- Parametrised display controller for the vending machine.
- Arbitrates among NUM_SCREENS display sources (main, customer select, admin, pay, endpay, income, sold-count, ...) with fixed priority, minimum hold time and a lock.
- Time-multiplexes the selected screen's BCD digits onto the 7-segment bus; sits between the mode/payment logic and the board pins.
- Replaces the per-screen decoder instances with one scan engine fed by BCD data.

Parameters:
- NUM_SCREENS, 8, number of screen sources; screen 0 is the main screen.
- NUM_DIGITS, 8, digits scanned (1..8).
- SCAN_DIV, 100000, clk cycles per digit step.
- MIN_HOLD, 50000000, minimum clk cycles a non-main screen stays shown after selection.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- disp_on  input  1  display enable; low forces OFF.
- req  input  NUM_SCREENS  request per screen; bit 0 ignored, main is the fallback.
- lock  input  1  freezes screen selection; used during payment.
- scr_data  input  NUM_SCREENS*NUM_DIGITS*4  BCD nibbles; screen s, digit d at [(s*NUM_DIGITS+d)*4 +: 4].
- cur_screen  output  $clog2(NUM_SCREENS)  index of the displayed screen.
- screen_chg  output  1  one-cycle pulse on every screen change.
- seg_en  output  NUM_DIGITS  one-hot digit enable, active-high.
- seg_out  output  8  segments; [0..6]=a..g, [7]=dp, active-high.

Behaviour:
- Reset (async, rst low): state OFF, cur_screen=0, screen_chg=0, seg_en=0, seg_out=0, scan/hold counters=0. Reset mid-scan or mid-hold aborts immediately.
- FSM states:
  - OFF: outputs blank. On disp_on=1, go to MAIN.
  - MAIN: cur_screen=0.
  - ACTIVE: cur_screen=k, k>0.
  - Any state: disp_on=0 -> OFF next cycle, seg_en=0.
- Winner: highest-index asserted req bit among 1..NUM_SCREENS-1.
- MAIN: a winner exists and lock=0 -> ACTIVE(winner) next cycle; hold counter loads MIN_HOLD-1.
- ACTIVE(k), lock=0:
  - Winner index > k: preempt immediately, hold counter reloads.
  - req[k] still high: stay.
  - req[k] low and hold counter != 0: stay, counter decrements.
  - req[k] low and hold counter = 0: if a lower winner exists go ACTIVE(winner), else MAIN.
  - The hold counter decrements every cycle in ACTIVE, saturating at 0.
- lock=1: no transitions except to OFF. The hold counter keeps decrementing. Pending requests are evaluated on the first cycle after lock falls.
- Screen change:
  - screen_chg pulses on the cycle cur_screen updates.
  - Digit index resets to 0 and the scan prescaler clears.
- Scan: prescaler counts 0..SCAN_DIV-1. On terminal count the digit index increments and wraps NUM_DIGITS-1 -> 0.
- Output register:
  - seg_en = 1<<digit.
  - seg_out = decode(nibble of cur_screen, digit).
  - seg_en and seg_out are registered one cycle after cur_screen/digit. Latency from req edge to new seg_out is 2 cycles.
- Decode:
  - 0-9: standard glyphs.
  - 0xA: '-' (g only).
  - 0xB: 'P'.
  - 0xC: 'C'.
  - 0xD-0xF: blank (seg_out=0, seg_en still asserted).
  - dp is always 0.
- Simultaneous events: disp_on=0 beats everything, then lock, then preemption. When req changes on the same cycle the hold counter expires, the new winner is used.

Optional Feature:
- Macro VEND_DISP_BLINK_EN.
- Enabled:
  - Extra input blink_mask (NUM_DIGITS); extra parameter BLINK_DIV, default 25000000.
  - A free-running toggle flips every BLINK_DIV cycles; it resets to 0 (visible phase).
  - While the toggle is 1, digits with blink_mask=1 output seg_out=0.
  - The toggle clears on screen_chg.
- Disabled: port and logic absent; all digits steady.

Test Plan:
- Reset and bring-up, SCAN_DIV=4, NUM_DIGITS=8: rst low -> seg_en=0, seg_out=0, cur_screen=0. Then rst high, disp_on=1 -> MAIN; seg_en steps 0x01,0x02,...,0x80,0x01 every 4 cycles.
- Decode: screen 0 digit 0=4'h3, digit 1=4'hA, digit 2=4'hE -> seg_out 0x4F, 0x40, 0x00 with seg_en 0x01, 0x02, 0x04.
- Priority/preempt, MIN_HOLD=10: req=0x04 -> cur_screen=2, one screen_chg pulse. Assert req bit 7 on cycle 3 -> cur_screen=7 next cycle, digit index back to 0.
- Hold: req=0x08 for 1 cycle then 0 -> cur_screen stays 3 for 10 cycles, then returns to 0 with a screen_chg pulse.
- Lock: in ACTIVE(3) assert lock, raise req bit 6 and drop bit 3 -> cur_screen stays 3. Release lock -> cur_screen=6 next cycle.
- Mid-operation: disp_on=0 during ACTIVE -> seg_en=0 within 1 cycle. Async rst pulse mid-scan -> all outputs 0 immediately, without a clock edge.
